nn_frame_scheduler: RTL and testbench
=====================================

Name: nn_frame_scheduler

Overview:
- Sequences one image from a pixel memory into stream_neural_net as a raster stream.
- Generates the VSYNC/HSYNC framing and the pixel bus, waits for the network's completion strobe, then latches the classification result.
- Sits between the host/control logic (start/done handshake) and the network input.
- Replaces the hand-driven raster loop used in simulation with synthesizable sequencing.

Parameters:
- IMG_W, 28, pixels per line
- IMG_H, 28, lines per frame
- DATA_WIDTH, 16, pixel width (fixed-point, matches network dataWidth)
- ADDR_WIDTH, 10, pixel memory address width; must satisfy 2**ADDR_WIDTH >= IMG_W*IMG_H
- H_BLANK, 0, idle cycles between lines with HSYNC low; 0 = back-to-back lines
- V_TAIL, 3, cycles VSYNC stays low after the last pixel before entering WAIT_RESULT
- RES_WIDTH, 4, class index width
- TIMEOUT, 4096, max cycles in WAIT_RESULT before abort

Ports:
- clk, in, 1, system clock (rising edge)
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle request to process a frame; honoured only in IDLE
- busy, out, 1, high from the cycle after start is accepted until done
- done, out, 1, one-cycle pulse when a frame completes or times out
- timeout_err, out, 1, valid with done; 1 = the network never signalled
- mem_addr, out, ADDR_WIDTH, pixel memory read address
- mem_rd, out, 1, read enable
- mem_rdata, in, DATA_WIDTH, read data, valid exactly 1 cycle after mem_rd
- pix, out, DATA_WIDTH, pixel to network (`in`)
- hsync, out, 1, line-active framing to network
- vsync, out, 1, frame-active framing to network
- net_done, in, 1, network final-layer done strobe
- net_result, in, RES_WIDTH, network argmax output
- result, out, RES_WIDTH, latched class
- result_valid, out, 1, high with done when timeout_err=0; holds until next start

Behaviour:
- Reset: state=IDLE. busy, done, timeout_err, mem_rd, hsync, vsync, result_valid all 0. mem_addr, pix, result all 0. Counters 0.
- FSM states and transitions:
  - IDLE -> PRIME on start.
  - PRIME: 1 cycle. Issues mem_rd at addr 0. Asserts vsync.
  - STREAM: one read per cycle. Address = line*IMG_W + col. At col==IMG_W-1: go to HBLANK if H_BLANK>0 and line<IMG_H-1, else stay in STREAM with the next line. After the last pixel, go to TAIL.
  - HBLANK: H_BLANK cycles, no reads, hsync=0, vsync=1.
  - TAIL: vsync=0, hsync=0, V_TAIL cycles.
  - WAIT_RESULT: count cycles.
    - On net_done: latch net_result -> DONE.
    - At count==TIMEOUT-1 with no net_done: set timeout_err -> DONE.
  - DONE: 1 cycle. done=1. -> IDLE.
- Alignment: pix, hsync and vsync are registered and change together. pix = mem_rdata of the read issued the previous cycle.
  - First pixel (addr 0) appears on pix the cycle after PRIME, with hsync=1 and vsync=1.
  - Exactly IMG_W*IMG_H cycles have hsync=1 per frame (H_BLANK=0).
  - Start to first pixel = 2 cycles.
- hsync is 1 for every cycle carrying a valid pixel and 0 otherwise. vsync rises with the PRIME read and falls on the first TAIL cycle.
- Outside the pixel window, pix holds its last value.
- net_done seen before WAIT_RESULT is ignored (not captured).
- net_done and timeout in the same cycle: net_done wins, timeout_err=0.
- start while busy: ignored, no queueing.
- start in the same cycle as DONE: ignored. start must be re-issued in IDLE.
- result/result_valid hold after done. result_valid clears on the next accepted start.
- Reset mid-frame: asynchronous return to reset values. No partial done pulse.
- Counters sized $clog2 of their limits; no wrap occurs within a frame.

Decomposition:
- Package nn_ctrl_pkg:
  - state enum (IDLE, PRIME, STREAM, HBLANK, TAIL, WAIT_RESULT, DONE)
  - localparam NPIX = IMG_W*IMG_H default (784)
  - result type width
- One natural sub-module: raster_counter. Col/line counters with last_col/last_pix flags and an address generator; reusable for the parameter loader.

Test Plan:
- Defaults, memory[k]=k. Pulse start at cycle 0 -> pix=0 with hsync=vsync=1 at cycle 2; pix=783 at cycle 785; hsync=1 for exactly 784 cycles; vsync falls at cycle 786.
- H_BLANK=2, IMG_W=IMG_H=4 -> hsync pattern 4 on, 2 off, repeated; last line has no trailing blank; 16 valid pixels in order 0..15.
- net_done with net_result=7, 10 cycles into WAIT_RESULT -> done pulse next cycle; result=7, result_valid=1, timeout_err=0, busy falls with done.
- No net_done, TIMEOUT=16 -> done after 16 WAIT_RESULT cycles; timeout_err=1, result_valid=0.
- start re-pulsed mid-STREAM, plus net_done pulsed during STREAM -> both ignored; frame completes normally and waits for a later net_done.
- rst_n low at pixel 300 -> all outputs 0 asynchronously; a fresh start restreams from addr 0.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared types for the frame scheduler
// and the raster counter.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    HBLANK,
    TAIL,
    WAIT_RESULT,
    DONE
  } state_t;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int NPIX      = IMG_W_DEF * IMG_H_DEF;
  localparam int RES_W     = 4;

  typedef logic [RES_W-1:0] result_t;

  // bits needed to count 0..limit-1, never zero
  function automatic int cnt_bits(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter: column/line walker with a linear
// address that tracks line*W+col.
module raster_counter
  import nn_ctrl_pkg::*;
#(
  parameter int W  = IMG_W_DEF,
  parameter int H  = IMG_H_DEF,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] addr,
  output logic          last_col,
  output logic          last_pix
);

  localparam int CB = cnt_bits(W);
  localparam int LB = cnt_bits(H);

  logic [CB-1:0] col;
  logic [LB-1:0] line;
  logic          last_line;

  assign last_col  = (col == CB'(W - 1));
  assign last_line = (line == LB'(H - 1));
  assign last_pix  = last_col && last_line;

  // step one pixel per adv, wrapping to origin after the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      line <= '0;
      addr <= '0;
    end else if (clr) begin
      col  <= '0;
      line <= '0;
      addr <= '0;
    end else if (adv) begin
      if (last_pix) begin
        col  <= '0;
        line <= '0;
        addr <= '0;
      end else if (last_col) begin
        col  <= '0;
        line <= line + 1'b1;
        addr <= addr + 1'b1;
      end else begin
        col  <= col + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_frame_scheduler.sv
// nn_frame_scheduler: streams one image into the
// network with sync framing, then captures its class.
module nn_frame_scheduler
  import nn_ctrl_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int H_BLANK    = 0,
  parameter int V_TAIL     = 3,
  parameter int RES_WIDTH  = RES_W,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] pix,
  output logic                  hsync,
  output logic                  vsync,
  input  logic                  net_done,
  input  logic [RES_WIDTH-1:0]  net_result,
  output logic [RES_WIDTH-1:0]  result,
  output logic                  result_valid
);

  localparam int M1 =
    (TIMEOUT > V_TAIL) ? TIMEOUT : V_TAIL;
  localparam int AUX_MAX =
    (M1 > H_BLANK) ? M1 : H_BLANK;
  localparam int CW = cnt_bits(AUX_MAX);

  state_t state, state_nx;

  logic [CW-1:0] cnt, cnt_nx;

  logic rd, adv, clr, accept;
  logic hit, expire, framing;
  logic last_col, last_pix;

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] pix_hold;

  raster_counter #(
    .W  (IMG_W),
    .H  (IMG_H),
    .AW (ADDR_WIDTH)
  ) u_raster (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .adv      (adv),
    .addr     (addr),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  // next state, read strobes and phase counter
  always_comb begin
    state_nx = state;
    rd       = 1'b0;
    adv      = 1'b0;
    clr      = 1'b0;
    accept   = 1'b0;
    hit      = 1'b0;
    expire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          clr      = 1'b1;
          state_nx = PRIME;
        end
      end
      PRIME, STREAM: begin
        rd  = 1'b1;
        adv = 1'b1;
        if (last_pix)
          state_nx = TAIL;
        else if (last_col && H_BLANK > 0)
          state_nx = HBLANK;
        else
          state_nx = STREAM;
      end
      HBLANK: begin
        if (cnt == CW'(H_BLANK - 1))
          state_nx = STREAM;
      end
      TAIL: begin
        if (cnt == CW'(V_TAIL - 1))
          state_nx = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (net_done) begin
          hit      = 1'b1;
          state_nx = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          expire   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    cnt_nx = '0;
    if (state_nx == state &&
        (state == HBLANK || state == TAIL ||
         state == WAIT_RESULT))
      cnt_nx = cnt + 1'b1;

    framing = accept || state == PRIME ||
              state == STREAM || state == HBLANK;
  end

  // state and phase counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // framing follows the read by one cycle, like the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      pix_hold <= '0;
    end else begin
      hsync <= rd;
      vsync <= framing;
      if (hsync)
        pix_hold <= mem_rdata;
    end
  end

  // classification capture; cleared when a new frame starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (accept) begin
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (hit) begin
      result       <= net_result;
      result_valid <= 1'b1;
    end else if (expire) begin
      timeout_err <= 1'b1;
    end
  end

  // read data arrives on the edge that raises hsync, so it
  // goes straight out while live and is held otherwise
  assign pix      = hsync ? mem_rdata : pix_hold;
  assign mem_rd   = rd;
  assign mem_addr = addr;
  assign busy     = state != IDLE && state != DONE;
  assign done     = state == DONE;

endmodule

// File: tb/tb_nn_frame_scheduler.sv
// tb_nn_frame_scheduler: directed vectors for the
// frame scheduler, default and small blanked images.
module tb_nn_frame_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rc = 0;

  logic        a_start = 1'b0;
  logic        a_busy, a_done, a_terr, a_rd;
  logic        a_hs, a_vs, a_rv;
  logic        a_net_done = 1'b0;
  logic [3:0]  a_net_res = '0;
  logic [3:0]  a_res;
  logic [9:0]  a_addr;
  logic [15:0] a_rdata = '0;
  logic [15:0] a_pix;

  logic        b_start = 1'b0;
  logic        b_busy, b_done, b_terr, b_rd;
  logic        b_hs, b_vs, b_rv;
  logic        b_net_done = 1'b0;
  logic [3:0]  b_net_res = '0;
  logic [3:0]  b_res;
  logic [3:0]  b_addr;
  logic [15:0] b_rdata = '0;
  logic [15:0] b_pix;

  nn_frame_scheduler u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start),
    .busy(a_busy), .done(a_done),
    .timeout_err(a_terr), .mem_addr(a_addr),
    .mem_rd(a_rd), .mem_rdata(a_rdata),
    .pix(a_pix), .hsync(a_hs), .vsync(a_vs),
    .net_done(a_net_done), .net_result(a_net_res),
    .result(a_res), .result_valid(a_rv)
  );

  nn_frame_scheduler #(
    .IMG_W(4), .IMG_H(4), .ADDR_WIDTH(4),
    .H_BLANK(2), .TIMEOUT(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .busy(b_busy), .done(b_done),
    .timeout_err(b_terr), .mem_addr(b_addr),
    .mem_rd(b_rd), .mem_rdata(b_rdata),
    .pix(b_pix), .hsync(b_hs), .vsync(b_vs),
    .net_done(b_net_done), .net_result(b_net_res),
    .result(b_res), .result_valid(b_rv)
  );

  always @(posedge clk) if (a_rd) a_rdata <= 16'(a_addr);
  always @(posedge clk) if (b_rd) b_rdata <= 16'(b_addr);

  typedef struct {
    int         rc;
    logic       hs;
    logic       vs;
    logic [15:0] pix;
    logic       busy;
    logic       done;
    logic       terr;
    logic       rv;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rc=%0d got %0d want %0d",
               nm, rc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rc++;
  endtask

  initial begin
    int k;
    int bad;
    int early;
    int ti;

    tv[0]  = '{1,  0, 1, 0,  1, 0, 0, 0};
    tv[1]  = '{2,  1, 1, 0,  1, 0, 0, 0};
    tv[2]  = '{3,  1, 1, 1,  1, 0, 0, 0};
    tv[3]  = '{5,  1, 1, 3,  1, 0, 0, 0};
    tv[4]  = '{6,  0, 1, 3,  1, 0, 0, 0};
    tv[5]  = '{7,  0, 1, 3,  1, 0, 0, 0};
    tv[6]  = '{8,  1, 1, 4,  1, 0, 0, 0};
    tv[7]  = '{11, 1, 1, 7,  1, 0, 0, 0};
    tv[8]  = '{12, 0, 1, 7,  1, 0, 0, 0};
    tv[9]  = '{14, 1, 1, 8,  1, 0, 0, 0};
    tv[10] = '{19, 0, 1, 11, 1, 0, 0, 0};
    tv[11] = '{20, 1, 1, 12, 1, 0, 0, 0};
    tv[12] = '{23, 1, 1, 15, 1, 0, 0, 0};
    tv[13] = '{24, 0, 0, 15, 1, 0, 0, 0};
    tv[14] = '{41, 0, 0, 15, 1, 0, 0, 0};
    tv[15] = '{42, 0, 0, 15, 0, 1, 1, 0};
    tv[16] = '{43, 0, 0, 15, 0, 0, 1, 0};
    tv[17] = '{44, 0, 0, 15, 0, 0, 1, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_vsync", 32'(a_vs), 0);
    chk("rst_hsync", 32'(a_hs), 0);
    chk("rst_rd", 32'(a_rd), 0);
    chk("rst_addr", 32'(a_addr), 0);
    chk("rst_pix", 32'(a_pix), 0);
    chk("rst_done", 32'(a_done), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(a_busy), 0);
    chk("idle_rv", 32'(a_rv), 0);

    // small image, H_BLANK=2, timeout path, start in DONE
    rc = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    k = 0;
    bad = 0;
    ti = 0;
    for (int c = 1; c <= 44; c++) begin
      if (b_hs) begin
        if (b_pix != 16'(k)) bad++;
        k++;
      end
      if (ti < 18 && tv[ti].rc == rc) begin
        chk("b_hsync", 32'(b_hs), 32'(tv[ti].hs));
        chk("b_vsync", 32'(b_vs), 32'(tv[ti].vs));
        chk("b_pix", 32'(b_pix), 32'(tv[ti].pix));
        chk("b_busy", 32'(b_busy), 32'(tv[ti].busy));
        chk("b_done", 32'(b_done), 32'(tv[ti].done));
        chk("b_terr", 32'(b_terr), 32'(tv[ti].terr));
        chk("b_rv", 32'(b_rv), 32'(tv[ti].rv));
        ti++;
      end
      b_start = (rc == 42);
      tick();
    end
    b_start = 1'b0;
    chk("b_pix_order", bad, 0);
    chk("b_hs_total", k, 16);
    chk("b_vec_reached", ti, 18);

    // net_done on the last timeout cycle wins
    rc = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b2_terr_clr", 32'(b_terr), 0);
    while (rc < 41) tick();
    b_net_done = 1'b1;
    b_net_res = 4'd9;
    tick();
    b_net_done = 1'b0;
    chk("b2_done", 32'(b_done), 1);
    chk("b2_terr", 32'(b_terr), 0);
    chk("b2_rv", 32'(b_rv), 1);
    chk("b2_res", 32'(b_res), 9);

    // full default frame with stray start/net_done mid-stream
    rc = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    k = 0;
    bad = 0;
    early = 0;
    for (int c = 1; c <= 800; c++) begin
      if (rc == 1) begin
        chk("a_prime_vs", 32'(a_vs), 1);
        chk("a_prime_hs", 32'(a_hs), 0);
        chk("a_prime_rd", 32'(a_rd), 1);
        chk("a_prime_addr", 32'(a_addr), 0);
        chk("a_prime_busy", 32'(a_busy), 1);
      end
      if (rc == 2) begin
        chk("a_first_pix", 32'(a_pix), 0);
        chk("a_first_hs", 32'(a_hs), 1);
        chk("a_first_vs", 32'(a_vs), 1);
      end
      if (a_hs) begin
        if (a_pix != 16'(k)) bad++;
        k++;
      end
      if (rc == 785) begin
        chk("a_last_pix", 32'(a_pix), 783);
        chk("a_last_hs", 32'(a_hs), 1);
        chk("a_last_vs", 32'(a_vs), 1);
      end
      if (rc == 786) begin
        chk("a_tail_vs", 32'(a_vs), 0);
        chk("a_tail_hs", 32'(a_hs), 0);
        chk("a_tail_pix", 32'(a_pix), 783);
      end
      if (rc >= 2 && rc <= 798 && a_done) early++;
      if (rc == 797) chk("a_wait_busy", 32'(a_busy), 1);
      if (rc == 799) begin
        chk("a_done", 32'(a_done), 1);
        chk("a_res", 32'(a_res), 7);
        chk("a_rv", 32'(a_rv), 1);
        chk("a_terr", 32'(a_terr), 0);
        chk("a_busy_fall", 32'(a_busy), 0);
      end
      if (rc == 800) begin
        chk("a_done_pulse", 32'(a_done), 0);
        chk("a_rv_hold", 32'(a_rv), 1);
        chk("a_res_hold", 32'(a_res), 7);
      end
      a_start = (rc == 100);
      a_net_done = (rc == 100) || (rc == 798);
      a_net_res = (rc == 798) ? 4'd7 : 4'd3;
      tick();
    end
    a_start = 1'b0;
    a_net_done = 1'b0;
    chk("a_pix_order", bad, 0);
    chk("a_hs_total", k, 784);
    chk("a_no_early_done", early, 0);

    // reset mid-frame at pixel 300
    rc = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a2_rv_clr", 32'(a_rv), 0);
    while (rc < 302) tick();
    chk("a2_pix300", 32'(a_pix), 300);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(a_busy), 0);
    chk("ar_hs", 32'(a_hs), 0);
    chk("ar_vs", 32'(a_vs), 0);
    chk("ar_rd", 32'(a_rd), 0);
    chk("ar_addr", 32'(a_addr), 0);
    chk("ar_pix", 32'(a_pix), 0);
    chk("ar_res", 32'(a_res), 0);
    chk("ar_done", 32'(a_done), 0);
    chk("br_res", 32'(b_res), 0);
    #2;
    rst_n = 1'b1;
    rc = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a3_rd", 32'(a_rd), 1);
    chk("a3_addr", 32'(a_addr), 0);
    tick();
    chk("a3_pix0", 32'(a_pix), 0);
    chk("a3_hs", 32'(a_hs), 1);
    tick();
    chk("a3_pix1", 32'(a_pix), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
